// File: rtl/demux_slot.sv
// Single-entry holding slot for one demux output channel.
// Holds one word from load until it is drained; a drain and a load in the same cycle keep it full.
module demux_slot #(
  parameter int unsigned in_size = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [in_size-1:0] load_data,
  input  logic               drain,
  output logic               full,
  output logic [in_size-1:0] data
);

  typedef enum logic {
    StEmpty,
    StFull
  } slot_state_e;

  slot_state_e        state_q;
  logic [in_size-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else if (load) begin
      state_q <= StFull;
      data_q  <= load_data;
    end else if (state_q == StFull && drain) begin
      // Data is left in place after draining; only the state changes.
      state_q <= StEmpty;
    end
  end

  assign full = (state_q == StFull);
  assign data = data_q;

endmodule

// File: rtl/selector_demux_parametrised.sv
// One-hot selected demultiplexer with a single-entry slot per output channel.
// Words with an illegal (not exactly one-hot) select are accepted, dropped and counted.
module selector_demux_parametrised #(
  parameter int unsigned in_size = 2,
  parameter int unsigned in_val  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [in_size-1:0]         s_data,
  input  logic [in_val-1:0]          s_sel,
  output logic [in_val-1:0]          m_valid,
  input  logic [in_val-1:0]          m_ready,
  output logic [in_size*in_val-1:0]  m_data,
  output logic                       err,
  output logic [7:0]                 err_cnt
);

  localparam int unsigned CntW = 8;

  logic [in_val-1:0] sel_minus_one;
  logic              sel_legal;
  logic [in_val-1:0] chan_ready;
  logic              accept;
  logic [in_val-1:0] load;

  logic              err_q;
  logic [CntW-1:0]   err_cnt_q;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    sel_minus_one = s_sel - in_val'(1);
    sel_legal     = (s_sel != '0) && ((s_sel & sel_minus_one) == '0);
  end

  always_comb begin
    chan_ready = ~m_valid | m_ready;
    s_ready    = sel_legal ? |(s_sel & chan_ready) : 1'b1;
    accept     = s_valid & s_ready;
    load       = (accept && sel_legal) ? s_sel : '0;
  end

  for (genvar i = 0; i < in_val; i++) begin : g_slot
    demux_slot #(
      .in_size(in_size)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .load_data(s_data),
      .drain    (m_ready[i]),
      .full     (m_valid[i]),
      .data     (m_data[i*in_size +: in_size])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept & ~sel_legal;
      if (accept && !sel_legal && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + CntW'(1);
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_selector_demux_parametrised.sv
// Self-checking bench for selector_demux_parametrised (in_size=2, in_val=4).
module tb_selector_demux_parametrised;

  localparam int unsigned NSize = 2;
  localparam int unsigned NVal  = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   s_valid;
  logic                   s_ready;
  logic [NSize-1:0]       s_data;
  logic [NVal-1:0]        s_sel;
  logic [NVal-1:0]        m_valid;
  logic [NVal-1:0]        m_ready;
  logic [NSize*NVal-1:0]  m_data;
  logic                   err;
  logic [7:0]             err_cnt;

  selector_demux_parametrised #(
    .in_size(NSize),
    .in_val (NVal)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_sel  (s_sel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .err    (err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per-channel occupancy and contents, plus drop bookkeeping.
  bit               mdl_full [NVal];
  logic [NSize-1:0] mdl_data [NVal];
  int               mdl_cnt;
  bit               mdl_err;
  bit               release_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NVal; i++) begin
      mdl_full[i] = 1'b0;
      mdl_data[i] = '0;
    end
    mdl_cnt = 0;
    mdl_err = 1'b0;
  endtask

  function automatic logic [NVal-1:0] mdl_mvalid();
    logic [NVal-1:0] v;
    for (int i = 0; i < NVal; i++) v[i] = mdl_full[i];
    return v;
  endfunction

  function automatic logic [NSize*NVal-1:0] mdl_mdata();
    logic [NSize*NVal-1:0] d;
    for (int i = 0; i < NVal; i++) d[i*NSize +: NSize] = mdl_data[i];
    return d;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".m_valid"}, 32'(m_valid), 32'(mdl_mvalid()));
    check({tag, ".m_data"},  32'(m_data),  32'(mdl_mdata()));
    check({tag, ".err"},     32'(err),     32'(mdl_err));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(mdl_cnt));
  endtask

  // One clock of stimulus: drive at negedge, check s_ready, step the model, check after posedge.
  task automatic step(input bit v, input logic [NVal-1:0] sel, input logic [NSize-1:0] d,
                      input logic [NVal-1:0] mr, output bit rdy);
    int  ones;
    int  k;
    bit  legal;
    bit  exp_rdy;
    bit  drained;
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
    end
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    m_ready = mr;
    #1;
    rdy  = s_ready;
    ones = 0;
    k    = 0;
    for (int i = 0; i < NVal; i++) begin
      if (sel[i]) begin
        ones++;
        k = i;
      end
    end
    legal   = (ones == 1);
    exp_rdy = legal ? (!mdl_full[k] || mr[k]) : 1'b1;
    if (v) check("s_ready", 32'(s_ready), 32'(exp_rdy));
    for (int i = 0; i < NVal; i++) begin
      drained = mdl_full[i] && mr[i];
      if (v && legal && exp_rdy && k == i) begin
        mdl_full[i] = 1'b1;
        mdl_data[i] = d;
      end else if (drained) begin
        mdl_full[i] = 1'b0;
      end
    end
    mdl_err = v && !legal;
    if (mdl_err && mdl_cnt < 255) mdl_cnt++;
    @(posedge clk);
    #1;
    check_model("step");
  endtask

  typedef struct {
    bit               v;
    logic [NVal-1:0]  sel;
    logic [NSize-1:0] d;
    logic [NVal-1:0]  mr;
    bit               chk_rdy;
    bit               exp_rdy;
    logic [NVal-1:0]  exp_mv;
    logic [7:0]       exp_md;
    bit               exp_err;
    int               exp_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bit              rdy;
    logic [NVal-1:0] rsel;
    int              r;

    // Routing, illegal drops and backpressure, in order from reset.
    tbl[0] = '{1'b1, 4'b0100, 2'b11, 4'b1111, 1'b1, 1'b1, 4'b0100, 8'h30, 1'b0, 0};
    tbl[1] = '{1'b0, 4'b0000, 2'b00, 4'b1111, 1'b0, 1'b0, 4'b0000, 8'h30, 1'b0, 0};
    tbl[2] = '{1'b1, 4'b0000, 2'b01, 4'b0000, 1'b1, 1'b1, 4'b0000, 8'h30, 1'b1, 1};
    tbl[3] = '{1'b1, 4'b0110, 2'b10, 4'b0000, 1'b1, 1'b1, 4'b0000, 8'h30, 1'b1, 2};
    tbl[4] = '{1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h30, 1'b0, 2};
    tbl[5] = '{1'b1, 4'b0010, 2'b01, 4'b0000, 1'b1, 1'b1, 4'b0010, 8'h34, 1'b0, 2};
    tbl[6] = '{1'b1, 4'b0010, 2'b10, 4'b0000, 1'b1, 1'b0, 4'b0010, 8'h34, 1'b0, 2};
    tbl[7] = '{1'b1, 4'b0010, 2'b10, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'h38, 1'b0, 2};
    tbl[8] = '{1'b0, 4'b0000, 2'b00, 4'b1111, 1'b0, 1'b0, 4'b0000, 8'h38, 1'b0, 2};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sel   = '0;
    s_data  = '0;
    m_ready = '0;
    release_pending = 1'b0;
    model_reset();
    #3;
    check("reset.m_valid", 32'(m_valid), 32'h0);
    check("reset.m_data",  32'(m_data),  32'h0);
    check("reset.err",     32'(err),     32'h0);
    check("reset.err_cnt", 32'(err_cnt), 32'h0);
    repeat (2) @(posedge clk);
    release_pending = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].mr, rdy);
      if (tbl[i].chk_rdy) check($sformatf("tbl%0d.s_ready", i), 32'(rdy), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].exp_mv));
      check($sformatf("tbl%0d.m_data", i),  32'(m_data),  32'(tbl[i].exp_md));
      check($sformatf("tbl%0d.err", i),     32'(err),     32'(tbl[i].exp_err));
      check($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].exp_cnt));
    end

    // Channel 0 blocked while channel 3 streams one word per clock.
    step(1'b1, 4'b0001, 2'b01, 4'b0000, rdy);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1000, 2'(i), 4'b1000, rdy);
      check("indep.s_ready", 32'(rdy), 32'h1);
      check("indep.ch3_valid", 32'(m_valid[3]), 32'h1);
      check("indep.ch3_data", 32'(m_data[7:6]), 32'(i % 4));
      check("indep.ch0_hold", 32'({m_valid[0], m_data[1:0]}), 32'h5);
    end
    step(1'b0, 4'b0000, 2'b00, 4'b1111, rdy);

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'(i % 2 == 0 ? 0 : 4'b1111), 2'(i), 4'b0000, rdy);
    end
    check("sat.err_cnt", 32'(err_cnt), 32'd255);
    check("sat.m_valid", 32'(m_valid), 32'h0);
    step(1'b0, 4'b0000, 2'b00, 4'b0000, rdy);
    check("sat.err_clear", 32'(err), 32'h0);

    // Reset in the middle of a cycle with three channels full.
    step(1'b1, 4'b0001, 2'b10, 4'b0000, rdy);
    step(1'b1, 4'b0010, 2'b11, 4'b0000, rdy);
    step(1'b1, 4'b0100, 2'b01, 4'b0000, rdy);
    check("prerst.m_valid", 32'(m_valid), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.m_valid", 32'(m_valid), 32'h0);
    check("midrst.m_data",  32'(m_data),  32'h0);
    check("midrst.err_cnt", 32'(err_cnt), 32'h0);
    @(posedge clk);
    #1;
    check("midrst.hold", 32'(m_valid), 32'h0);
    release_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, 2'b00, 4'b0000, rdy);
      check("postrst.no_stale", 32'(m_valid), 32'h0);
    end

    // First acceptance on the first edge after release.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    release_pending = 1'b1;
    step(1'b1, 4'b0100, 2'b10, 4'b0000, rdy);
    check("firstedge.m_valid", 32'(m_valid), 32'h4);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) rsel = 4'(1 << $urandom_range(0, NVal - 1));
      else rsel = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), rsel, 2'($urandom), 4'($urandom), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_demux_parametrised.md
SELECTOR_DEMUX_PARAMETRISED -- requirements
Module: selector_demux_parametrised

Interface
REQ-001 Parameter in_size, default 2: data width in bits of one channel.
REQ-002 Parameter in_val, default 4: number of output channels; the one-hot select has this width.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  upstream word accepted when s_valid and s_ready are both high at a clk edge.
REQ-008 s_data  input  in_size  upstream word.
REQ-009 s_sel  input  in_val  one-hot destination; bit i selects channel i; qualified by s_valid.
REQ-010 m_valid  output  in_val  bit i: channel i holds a word.
REQ-011 m_ready  input  in_val  bit i: downstream i consumes the word.
REQ-012 m_data  output  in_size*in_val  packed; channel i is at bits [(i+1)*in_size-1 : i*in_size].
REQ-013 err  output  1  one-cycle pulse when an illegal select is dropped.
REQ-014 err_cnt  output  8  saturating count of dropped words.

Function
REQ-015 Each channel SHALL have one single-entry holding slot with two states: EMPTY and FULL.
- m_valid[i] SHALL equal FULL.
- m_data slice i SHALL be the slot contents.
REQ-016 The select is legal when exactly one bit of s_sel is set. Zero bits set or more than one bit set SHALL be treated as illegal.
REQ-017 For a legal select to channel k: s_ready = !m_valid[k] | m_ready[k]. This is combinational, with no dependence on other channels.
REQ-018 For an illegal select: s_ready SHALL be 1. On acceptance:
- the word is dropped;
- err pulses high for one cycle on the following cycle;
- err_cnt increments by 1 and saturates at 255 with no wrap.
REQ-019 Accepted legal word to channel k:
- slot k loads s_data at the edge;
- m_valid[k] is high in the next cycle, giving 1-cycle latency.
REQ-020 A slot SHALL transition FULL->EMPTY at the edge where m_valid[k] & m_ready[k] and no new word is loaded into slot k.
REQ-021 Simultaneous drain and load on the same channel: the slot stays FULL with the new data, and throughput is one word per clock per channel.
REQ-022 While m_valid[k] & !m_ready[k], m_data slice k SHALL stay stable.
REQ-023 Channels other than the selected one SHALL be unaffected by acceptance and may drain independently in the same cycle.
REQ-024 With s_valid low: s_ready is don't-care, no slot loads, and err is 0.
REQ-025 m_ready[i] while m_valid[i] is low SHALL have no effect.

Reset
REQ-026 While rst_n is low, regardless of clk:
- all slots are EMPTY (m_valid = 0);
- m_data = 0, err = 0, err_cnt = 0.
REQ-027 Reset assertion mid-transfer SHALL discard all held words. No word SHALL be emitted after reset release unless it is newly accepted.
REQ-028 The first acceptance SHALL be possible on the first clk edge after rst_n deasserts.

Structure
REQ-029 No shared package is used. Counter width 8 SHALL be a localparam in this module.
REQ-030 The single-entry slot SHALL be a sub-module demux_slot, parameterised by in_size and instantiated in_val times in a generate loop.
REQ-031 Legal-select detection and err_cnt SHALL live in the top module.

Verification
REQ-032 Basic routing: in_size=2, in_val=4, s_sel=4'b0100, s_data=2'b11, m_ready=4'b1111 -> next cycle m_valid=4'b0100 and m_data[5:4]=2'b11; the cycle after, m_valid=0.
REQ-033 Backpressure: channel 1 FULL, m_ready[1]=0, new word with s_sel=4'b0010 -> s_ready=0 and m_data[3:2] holds; then raise m_ready[1] -> s_ready=1 and the new word appears the following cycle.
REQ-034 Independence: channel 0 blocked (FULL, m_ready[0]=0), stream to channel 3 at one word per clock -> s_ready=1 every cycle and channel 3 receives all words in order.
REQ-035 Illegal selects: s_sel=4'b0000, then 4'b0110 -> s_ready=1, err pulses twice, err_cnt=2, and all m_valid remain 0. Then 300 more illegal words -> err_cnt=255.
REQ-036 Reset mid-operation: three channels FULL, assert rst_n=0 mid-cycle -> m_valid=0 and m_data=0 immediately; after release, no stale word appears.
